// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and width helpers for the round-robin lock
//               arbiter (state encoding, index-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  // Arbiter FSM: waiting for a request, or holding a locked grant.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Narrowest usable index width; never returns 0 so a bus is always legal.
  localparam int unsigned ARB_MIN_IDX_W = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : ARB_MIN_IDX_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_lock_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotated-priority pick. Returns the first set
//               request bit at or above the pointer, wrapping to bit 0.
//               The request vector is duplicated side by side so the
//               wrap-around is a plain lowest-set-bit search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] pick,
  output logic [IDX_W-1:0]     pick_idx
);

  localparam int DW = 2 * NUM_PORTS;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] keep_mask;
  logic [DW-1:0] masked;
  int            first_i;

  // Upper copy supplies the wrapped candidates, lower copy is masked below ptr.
  assign dbl_req   = {req, req};
  assign keep_mask = ~((DW'(1) << ptr) - DW'(1));
  assign masked    = dbl_req & keep_mask;

  // Lowest set bit of the masked double-width vector (downward scan, last hit wins).
  always_comb begin
    first_i = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) first_i = i;
    end
  end

  // Fold the double-width position back to a port index and one-hot pick.
  always_comb begin
    pick_idx = '0;
    pick     = '0;
    if (|masked) begin
      pick_idx = IDX_W'((first_i >= NUM_PORTS) ? (first_i - NUM_PORTS) : first_i);
      pick     = NUM_PORTS'(1) << pick_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Round-robin arbiter with grant locking. The winner keeps a
//               registered one-hot grant until done_i, until its request
//               drops, or (ARB_BURST_LIMIT_EN defined) until it has held the
//               grant MAX_BURST cycles while another port is waiting.
//               Compile-time option: ARB_BURST_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic                         gnt_valid_o,
  output logic [idx_width(NUM_PORTS)-1:0] gnt_id_o
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  // Elaboration-time parameter sanity checks.
  if (NUM_PORTS < 2) begin : g_chk_ports
    $error("rr_lock_arbiter: NUM_PORTS must be at least 2");
  end
  if (MAX_BURST < 2) begin : g_chk_burst
    $error("rr_lock_arbiter: MAX_BURST must be at least 2");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     id_q, id_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 release_grant;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = idx_width(MAX_BURST);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 at_limit;
  logic                 others_waiting;
`endif

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req      (req_i),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // State, grant, owner, pointer and burst-count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: grant from IDLE, release from GRANT, pointer moves only on release.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    id_d          = id_q;
    ptr_d         = ptr_q;
    release_grant = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d          = cnt_q;
    at_limit       = (cnt_q == CNT_W'(MAX_BURST - 1));
    others_waiting = |(req_i & ~gnt_q);
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          gnt_d   = pick;
          id_d    = pick_idx;
          state_d = ARB_GRANT;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        release_grant = done_i || !req_i[id_q];
`ifdef ARB_BURST_LIMIT_EN
        // Count saturates so a lone owner keeps the grant indefinitely.
        if (!at_limit) cnt_d = cnt_q + CNT_W'(1);
        if (at_limit && others_waiting) release_grant = 1'b1;
`endif
        if (release_grant) begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
          ptr_d   = (id_q == IDX_W'(NUM_PORTS - 1)) ? '0 : (id_q + IDX_W'(1));
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_id_o    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Scoreboard bench for rr_lock_arbiter. A transaction-level
//               reference model predicts each grant (owner and start cycle)
//               and each grant length; a monitor compares them against the
//               DUT. Honours ARB_BURST_LIMIT_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;

  logic         clk;
  logic         rst_ni;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  rr_lock_arbiter #(
    .NUM_PORTS (N),
    .MAX_BURST (MB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int owner;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model state: owner (-1 = nobody), rotation start, cycles held.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_len   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called once per rising edge with the inputs the DUT just sampled.
  task automatic model_update();
    bit rel;
    cyc++;
    if (!rst_ni) return;
    if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        exp_q.push_back('{owner: m_owner, cyc: cyc});
        m_len = 0;
      end
    end else begin
      m_len++;
      rel = done || !req[m_owner];
`ifdef ARB_BURST_LIMIT_EN
      if (m_len >= MB && (req & ~(N'(1) << m_owner)) != '0) rel = 1'b1;
`endif
      if (rel) begin
        len_q.push_back(m_len);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    model_update();
  endtask

  // Monitor: invariants every cycle, scoreboard pop on grant start and end.
  initial begin
    bit   prev_v;
    int   dut_len;
    exp_t e;
    prev_v  = 1'b0;
    dut_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_v  = 1'b0;
        dut_len = 0;
      end else begin
        chk("valid_is_or", int'(gnt_valid), int'(|gnt));
        if (gnt_valid) chk("gnt_matches_id", int'(gnt), int'(N'(1) << gnt_id));
        if (gnt_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("grant_owner", int'(gnt_id), e.owner);
            chk("grant_cycle", cyc, e.cyc);
          end
          dut_len = 1;
        end else if (gnt_valid) begin
          dut_len++;
        end else if (prev_v) begin
          if (len_q.size() == 0) chk("unexpected_release", 1, 0);
          else chk("grant_length", dut_len, len_q.pop_front());
        end
        prev_v = gnt_valid;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [N-1:0] r;
    rst_ni = 1'b0;
    req    = 4'b1111;
    done   = 1'b0;

    // Outputs stay cleared while reset is held with all ports requesting.
    repeat (3) begin
      @(negedge clk);
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_valid", int'(gnt_valid), 0);
      chk("reset_id", int'(gnt_id), 0);
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("first_grant_port0", int'(gnt), 1);
    @(posedge clk);
    model_update();

    // All ports requesting, each grant finished immediately: order 0,1,2,3,0.
    repeat (12) step(4'b1111, 1'b1);

    // Randomised requests and done pulses.
    r = '0;
    repeat (400) begin
      for (int p = 0; p < N; p++) begin
        if (r[p]) r[p] = ($urandom_range(0, 5) != 0);
        else      r[p] = ($urandom_range(0, 2) == 0);
      end
      step(r, ($urandom_range(0, 7) == 0));
    end

    // Single requester held for 20+ cycles: never preempted.
    repeat (3) step(4'b0000, 1'b0);
    repeat (22) step(4'b0010, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // Two ports contending with no done: burst alternation when enabled.
    repeat (40) step(4'b0011, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a held grant.
    repeat (3) step(4'b1111, 1'b0);
    @(negedge clk);
    chk("held_before_reset", int'(gnt_valid), 1);
    @(posedge clk);
    model_update();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_gnt", int'(gnt), 0);
    chk("async_reset_valid", int'(gnt_valid), 0);
    chk("async_reset_id", int'(gnt_id), 0);
    exp_q.delete();
    len_q.delete();
    m_owner = -1;
    m_ptr   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    req    = 4'b1110;
    done   = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("restart_from_port0", int'(gnt), 2);
    @(posedge clk);
    model_update();
    repeat (30) step(4'b1111, ($urandom_range(0, 2) == 0));

    // Drain so every predicted transaction is retired.
    repeat (4) step(4'b0000, 1'b0);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("len_queue_empty", len_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
